// File: rtl/run_timer.sv
// run_timer: a one-shot run-length timer.
// A start request launches a run of in_len clock cycles. The run either
// completes with a done pulse or is cancelled by an abort pulse. out_cnt
// counts the RUN cycles and keeps its final value until the next start.
//
//   state  | meaning
//   -------+---------------------------------------------------------
//   IDLE   | waiting for in_start; out_cnt holds the last run's count
//   RUN    | counting cycles toward the latched length
//   DONE   | one-cycle completion pulse on out_done
//   ABORT  | one-cycle cancel pulse on out_abort; out_cnt frozen
module run_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_start,
    input  logic [WIDTH-1:0] in_len,
    input  logic             in_abort,
    output logic             out_busy,
    output logic             out_done,
    output logic             out_abort,
    output logic [WIDTH-1:0] out_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DONE  = 2'd2,
        S_ABORT = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] len_q, len_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;

    // State, latched length and run counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and datapath update; abort wins over completion in RUN.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (in_start) begin
                    cnt_d = '0;
                    if (in_len != '0) begin
                        len_d   = in_len;
                        state_d = S_RUN;
                    end else begin
                        // Zero-length run skips RUN entirely.
                        state_d = S_DONE;
                    end
                end
            end
            S_RUN: begin
                if (in_abort) begin
                    state_d = S_ABORT;
                end else begin
                    // cnt_q < len_q here, so the increment cannot wrap.
                    cnt_d = cnt_q + ONE;
                    if (cnt_q == len_q - ONE) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ABORT: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Moore outputs decoded from the registered state only.
    always_comb begin
        out_busy  = (state_q != S_IDLE);
        out_done  = (state_q == S_DONE);
        out_abort = (state_q == S_ABORT);
        out_cnt   = cnt_q;
    end

endmodule
